reg_share_arbiter: RTL and testbench
====================================

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the shared register and of each requester data lane.
REQ-002 Parameter MAXHOLD, default 4, maximum number of register loads per grant (legal range 1..15).
REQ-003 Port CLK  input  1  rising-edge clock; all state changes on posedge CLK.
REQ-004 Port RST  input  1  reset, synchronous, active-high.
REQ-005 Port REQ  input  4  request per requester; REQ[i] high = requester i wants the shared register.
REQ-006 Port DIN  input  4*WIDTH  data lanes; requester i drives DIN[i*WIDTH +: WIDTH].
REQ-007 Port GNT  output  4  registered one-hot grant; all zero when no owner.
REQ-008 Port OWNER  output  2  index of current or last granted requester.
REQ-009 Port BUSY  output  1  high while any GNT bit is high.
REQ-010 Port Q  output  WIDTH  shared register contents, built from edge-triggered D storage.
REQ-011 Port UPD  output  1  one-cycle pulse, high in the cycle after Q was loaded.

Function
REQ-012 The block SHALL implement the FSM states IDLE and OWN.
REQ-013 IDLE: at an edge with REQ != 0, the block SHALL grant the first requester with REQ high, searching upward from round-robin pointer PTR modulo 4.
REQ-014 At that edge the block SHALL set GNT to that one-hot value, set OWNER to the winner, set hold count CNT to 0 and move to OWN; Q SHALL NOT load at the arbitration edge.
REQ-015 IDLE with REQ == 0: the block SHALL hold all state, with GNT = 0.
REQ-016 OWN, edge with REQ[OWNER] = 0: the block SHALL release (GNT = 0, PTR = OWNER+1 mod 4, go to IDLE), with no load.
REQ-017 OWN, edge with REQ[OWNER] = 1: the block SHALL load Q from the OWNER lane and increment CNT.
REQ-018 If the incremented CNT equals MAXHOLD, the block SHALL release at that same edge, as in REQ-016.
REQ-019 A grant SHALL therefore produce at most MAXHOLD loads, with at least one IDLE cycle (GNT = 0) between consecutive grants.
REQ-020 Requests from non-owners during OWN SHALL be ignored; DIN of non-owners SHALL never reach Q.
REQ-021 UPD SHALL be high exactly in cycles following a load edge; Q SHALL hold its value in all other cycles.
REQ-022 GNT SHALL be one-hot or zero in every cycle; BUSY SHALL equal |GNT.
REQ-023 PTR SHALL wrap 3 -> 0.
REQ-024 With a single persistent requester, that requester SHALL be re-granted after each one-cycle IDLE gap.

Reset
REQ-025 At an edge with RST = 1, the block SHALL set state = IDLE, GNT = 0, OWNER = 0, BUSY = 0, Q = 0, UPD = 0, PTR = 0 and CNT = 0, regardless of other inputs.
REQ-026 RST SHALL take priority over arbitration and loading; RST asserted during OWN SHALL abort the grant with no load at that edge.
REQ-027 Outputs SHALL be defined (zero) from the first clock edge with RST high; no asynchronous behaviour is permitted.

Verification
REQ-028 Single request: RST, then REQ = 0001 held, DIN0 = 8'hA5 -> GNT = 0001 after 1 edge; 4 loads with Q = A5 and UPD pulsing; GNT = 0 for 1 cycle; then re-grant.
REQ-029 Round-robin: REQ = 1111 held, distinct DIN values -> grant order 0, 1, 2, 3, 0, each granted for exactly 4 loads, one IDLE gap between grants.
REQ-030 Early drop: owner 2 drops REQ after 2 loads -> exactly 2 loads; release at the next edge; PTR = 3, so REQ = 1011 next grants requester 3.
REQ-031 Isolation: owner 1 active and REQ[0] toggling with DIN0 = 8'hFF -> Q never equals FF while GNT = 0010.
REQ-032 Reset mid-grant: RST pulsed while GNT = 0100 after 1 load -> next cycle GNT = 0, Q = 0, UPD = 0, OWNER = 0; with REQ = 0100, the next grant goes to requester 2 (search from PTR = 0).
REQ-033 MAXHOLD = 1: REQ = 0011 held -> alternating grants 0 and 1, one load each, GNT pattern 0001, 0000, 0010, 0000, repeating.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that lends one shared WIDTH-bit register to one of four
// requesters at a time, with at most MAXHOLD loads per grant.
module reg_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MAXHOLD = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [3:0]         REQ,
    input  logic [4*WIDTH-1:0] DIN,
    output logic [3:0]         GNT,
    output logic [1:0]         OWNER,
    output logic               BUSY,
    output logic [WIDTH-1:0]   Q,
    output logic               UPD
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [3:0] MAXHOLD_C = 4'(MAXHOLD);

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               upd_q, upd_d;
    logic               busy_q, busy_d;

    logic               win_found_s;
    logic [1:0]         win_idx_s;
    logic [1:0]         cand_s;
    logic [WIDTH-1:0]   lane_s;
    logic [3:0]         cnt_inc_s;

    // Winner search: first asserted request at or above the round-robin pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand_s = ptr_q + 2'(i);
            if (!win_found_s && REQ[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Owner's data lane; only this lane can ever reach the register.
    always_comb begin
        case (owner_q)
            2'd0:    lane_s = DIN[0*WIDTH +: WIDTH];
            2'd1:    lane_s = DIN[1*WIDTH +: WIDTH];
            2'd2:    lane_s = DIN[2*WIDTH +: WIDTH];
            2'd3:    lane_s = DIN[3*WIDTH +: WIDTH];
            default: lane_s = {WIDTH{1'b0}};
        endcase
    end

    assign cnt_inc_s = cnt_q + 4'd1;

    // Next-state and output decode for the IDLE/OWN controller.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        upd_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_OWN;
                    gnt_d   = 4'b0001 << win_idx_s;
                    owner_d = win_idx_s;
                    cnt_d   = 4'd0;
                end else begin
                    gnt_d   = 4'b0000;
                end
            end
            ST_OWN: begin
                if (!REQ[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                end else begin
                    q_d   = lane_s;
                    upd_d = 1'b1;
                    cnt_d = cnt_inc_s;
                    // Hold budget exhausted: release on the same edge as the last load.
                    if (cnt_inc_s == MAXHOLD_C) begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        ptr_d   = owner_q + 2'd1;
                    end else begin
                        state_d = ST_OWN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        busy_d = |gnt_d;
    end

    // State register with synchronous reset taking priority over all activity.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            q_q     <= {WIDTH{1'b0}};
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT   = gnt_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;
    assign Q     = q_q;
    assign UPD   = upd_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: default instance (MAXHOLD=4) plus a
// MAXHOLD=1 instance sharing clock and reset.
module tb_reg_share_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ, REQ1;
    logic [31:0] DIN, DIN1;
    logic [3:0]  GNT, GNT1;
    logic [1:0]  OWNER, OWNER1;
    logic        BUSY, BUSY1;
    logic [7:0]  Q, Q1;
    logic        UPD, UPD1;

    int n_checks = 0;
    int n_fail   = 0;

    reg_share_arbiter #(.WIDTH(8), .MAXHOLD(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN),
        .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY), .Q(Q), .UPD(UPD)
    );

    reg_share_arbiter #(.WIDTH(8), .MAXHOLD(1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ(REQ1), .DIN(DIN1),
        .GNT(GNT1), .OWNER(OWNER1), .BUSY(BUSY1), .Q(Q1), .UPD(UPD1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt1 [8];
        logic [7:0] lane_val;
        int g;

        RST  = 1'b1;
        REQ  = 4'b0000;
        REQ1 = 4'b0000;
        DIN  = 32'h0000_0000;
        DIN1 = 32'h0000_0000;
        tick();
        tick();
        check("rst_gnt",   {28'd0, GNT},   32'h0);
        check("rst_q",     {24'd0, Q},     32'h0);
        check("rst_upd",   {31'd0, UPD},   32'h0);
        check("rst_owner", {30'd0, OWNER}, 32'h0);
        check("rst_busy",  {31'd0, BUSY},  32'h0);

        // Single persistent requester with the default hold budget.
        RST = 1'b0;
        REQ = 4'b0001;
        DIN = 32'h0000_00A5;
        tick();
        check("single_gnt",  {28'd0, GNT},  32'h1);
        check("single_busy", {31'd0, BUSY}, 32'h1);
        check("single_upd0", {31'd0, UPD},  32'h0);
        check("single_q0",   {24'd0, Q},    32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("single_load_upd", {31'd0, UPD}, 32'h1);
            check("single_load_q",   {24'd0, Q},   32'hA5);
            check("single_load_gnt", {28'd0, GNT}, (k < 4) ? 32'h1 : 32'h0);
        end
        check("single_gap_busy", {31'd0, BUSY}, 32'h0);
        tick();
        check("single_regnt",     {28'd0, GNT}, 32'h1);
        check("single_regnt_upd", {31'd0, UPD}, 32'h0);
        check("single_hold_q",    {24'd0, Q},   32'hA5);
        REQ = 4'b0000;
        tick();
        check("single_drop_gnt", {28'd0, GNT}, 32'h0);
        check("single_drop_upd", {31'd0, UPD}, 32'h0);

        // Round robin over all four requesters.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ = 4'b1111;
        DIN = 32'h4433_2211;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            lane_val = 8'h11 * 8'(g + 1);
            tick();
            check("rr_gnt",   {28'd0, GNT},   32'h1 << g);
            check("rr_owner", {30'd0, OWNER}, 32'(g));
            for (int k = 1; k <= 4; k++) begin
                tick();
                check("rr_q",   {24'd0, Q},   {24'd0, lane_val});
                check("rr_upd", {31'd0, UPD}, 32'h1);
                check("rr_gnt_hold", {28'd0, GNT}, (k < 4) ? (32'h1 << g) : 32'h0);
            end
        end
        REQ = 4'b0000;
        tick();

        // Early drop by owner 2 after two loads; pointer then favours requester 3.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ = 4'b0100;
        tick();
        check("drop_gnt", {28'd0, GNT}, 32'h4);
        tick();
        tick();
        check("drop_q2",   {24'd0, Q},   32'h33);
        check("drop_upd2", {31'd0, UPD}, 32'h1);
        REQ = 4'b1011;
        tick();
        check("drop_rel_gnt", {28'd0, GNT}, 32'h0);
        check("drop_rel_upd", {31'd0, UPD}, 32'h0);
        check("drop_rel_q",   {24'd0, Q},   32'h33);
        tick();
        check("drop_next_gnt",   {28'd0, GNT},   32'h8);
        check("drop_next_owner", {30'd0, OWNER}, 32'h3);
        REQ = 4'b0000;
        tick();
        check("drop3_rel_gnt", {28'd0, GNT}, 32'h0);

        // Isolation: requester 0 toggles with all-ones data while 1 owns.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        DIN = 32'h0000_5AFF;
        REQ = 4'b0010;
        tick();
        check("iso_gnt", {28'd0, GNT}, 32'h2);
        for (int k = 1; k <= 4; k++) begin
            REQ = (k % 2 == 1) ? 4'b0011 : 4'b0010;
            tick();
            check("iso_q",   {24'd0, Q},   32'h5A);
            check("iso_gnt_hold", {28'd0, GNT}, (k < 4) ? 32'h2 : 32'h0);
        end
        REQ = 4'b0000;
        tick();

        // Reset in the middle of a grant to requester 2.
        DIN = 32'h4433_2211;
        REQ = 4'b0100;
        tick();
        check("rmid_gnt", {28'd0, GNT}, 32'h4);
        tick();
        check("rmid_load_q", {24'd0, Q}, 32'h33);
        RST = 1'b1;
        tick();
        check("rmid_gnt0",   {28'd0, GNT},   32'h0);
        check("rmid_q0",     {24'd0, Q},     32'h0);
        check("rmid_upd0",   {31'd0, UPD},   32'h0);
        check("rmid_owner0", {30'd0, OWNER}, 32'h0);
        RST = 1'b0;
        tick();
        check("rmid_regnt",       {28'd0, GNT},   32'h4);
        check("rmid_regnt_owner", {30'd0, OWNER}, 32'h2);
        REQ = 4'b0000;
        tick();

        // MAXHOLD = 1 instance: alternating single-load grants.
        exp_gnt1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                     4'b0001, 4'b0000, 4'b0010, 4'b0000};
        REQ1 = 4'b0011;
        DIN1 = 32'h0000_3CC3;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("mh1_gnt", {28'd0, GNT1}, {28'd0, exp_gnt1[n]});
            check("mh1_upd", {31'd0, UPD1}, (n % 2 == 1) ? 32'h1 : 32'h0);
            if (n % 2 == 1) begin
                check("mh1_q", {24'd0, Q1}, (n % 4 == 1) ? 32'hC3 : 32'h3C);
            end else begin
                check("mh1_busy", {31'd0, BUSY1}, 32'h1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
